// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory, redirect and decode-side signal bundle
interface fetch_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [4:0]         if_opcode;
  logic [PC_W-1:0]    if_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_opcode, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_opcode, if_pc,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with fetch FIFO; FETCH_HALT_EN enables halt on opcode 5'h1F
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    resp_pc_q;
  logic               req_q;
  logic               inflight_q;
  logic [CW-1:0]      count_q;
  logic [AW-1:0]      wr_q;
  logic [AW-1:0]      rd_q;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  logic               redirect;
  logic               push;
  logic               pop;
  logic               inflight_n;
  logic               halt_n;
  logic               req_n;
  logic [CW-1:0]      count_n;
  logic [CW:0]        occ_n;

  assign redirect = bus.redirect_valid;

  // The request shown in a redirect cycle is treated as never issued; its data is dropped.
  always_comb begin
    pop        = (count_q != '0) && bus.if_ready;
    push       = inflight_q && !redirect;
    inflight_n = req_q && !redirect;
    count_n    = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      count_n = '0;
    end
    occ_n = {1'b0, count_n} + (CW+1)'(inflight_n);
    req_n = (occ_n < (CW+1)'(DEPTH)) && !halt_n;
  end

`ifdef FETCH_HALT_EN
  logic halt_q;

  always_comb begin
    halt_n = halt_q || (push && (bus.imem_rdata[INSTR_W-1 -: 5] == 5'h1F));
    if (redirect) begin
      halt_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_n;
    end
  end
`else
  assign halt_n = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= '0;
      req_q      <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      req_q      <= req_n;
      inflight_q <= inflight_n;
      count_q    <= count_n;
      resp_pc_q  <= pc_q;
      if (redirect) begin
        pc_q <= bus.redirect_pc;
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (req_q) begin
          pc_q <= pc_q + PC_W'(4);
        end
        if (push) begin
          instr_mem[wr_q] <= bus.imem_rdata;
          pc_mem[wr_q]    <= resp_pc_q;
          wr_q            <= wr_q + AW'(1);
        end
        if (pop) begin
          rd_q <= rd_q + AW'(1);
        end
      end
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (count_q != '0);
  assign bus.if_instr  = instr_mem[rd_q];
  assign bus.if_opcode = instr_mem[rd_q][INSTR_W-1 -: 5];
  assign bus.if_pc     = pc_mem[rd_q];
endmodule
